pipeline_hazard_ctrl: RTL and testbench

Central hazard controller for the five-stage MIPS pipeline. It decides each cycle whether the PC and the IF_ID, ID_EX, EX_MEM and MEM_WB pipeline registers advance, hold or take a bubble. It generates EX-stage forwarding selects and runs the data-memory request/acknowledge handshake, including a wait-state timeout. It sits beside the pipeline registers and drives their enable and flush inputs.

---
 rtl/pipe_ctrl_pkg.sv | 16 +
 rtl/pipeline_hazard_ctrl_forward_unit.sv | 30 +++
 rtl/pipeline_hazard_ctrl.sv | 172 +++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } hazard_state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam int WAIT_MAX_DEFAULT = 16;

endpackage

// File: rtl/pipeline_hazard_ctrl_forward_unit.sv
// EX-stage operand forwarding selects; MEM result wins over WB result.
module forward_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] ex_rs,
  input  logic [4:0] ex_rt,
  input  logic [4:0] mem_rd,
  input  logic       mem_regwrite,
  input  logic [4:0] wb_rd,
  input  logic       wb_regwrite,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  // Register $0 is hardwired, so a write to it never produces a forwardable value.
  function automatic logic [1:0] pick_source(input logic [4:0] src);
    if (mem_regwrite && (mem_rd != 5'd0) && (mem_rd == src))
      return FWD_MEM;
    else if (wb_regwrite && (wb_rd != 5'd0) && (wb_rd == src))
      return FWD_WB;
    else
      return FWD_RF;
  endfunction

  always_comb begin
    fwd_a = pick_source(ex_rs);
    fwd_b = pick_source(ex_rt);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard controller: stall/flush/enable decisions, forwarding and dmem handshake.
// Optional performance counters are built when HAZ_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = WAIT_MAX_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  ex_rs,
  input  logic [4:0]  ex_rt,
  input  logic [4:0]  ex_rd,
  input  logic        ex_memread,
  input  logic        ex_branch_taken,
  input  logic [4:0]  mem_rd,
  input  logic        mem_regwrite,
  input  logic        mem_memread,
  input  logic        mem_memwrite,
  input  logic [4:0]  wb_rd,
  input  logic        wb_regwrite,
  input  logic        dmem_ack,
  output logic        dmem_req,
  output logic        pc_we,
  output logic        if_id_we,
  output logic        id_ex_we,
  output logic        ex_mem_we,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        mem_wb_flush,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic        dmem_err,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
);

  localparam int CW = $clog2(WAIT_MAX) + 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_MAX - 1);

  hazard_state_e state, state_next;
  logic [CW-1:0] wait_cnt, wait_cnt_next;
  logic          err_q;
  logic          mem_access;
  logic          frozen;
  logic          load_use;
  logic [1:0]    fwd_a_raw, fwd_b_raw;

  forward_unit u_forward (
    .ex_rs        (ex_rs),
    .ex_rt        (ex_rt),
    .mem_rd       (mem_rd),
    .mem_regwrite (mem_regwrite),
    .wb_rd        (wb_rd),
    .wb_regwrite  (wb_regwrite),
    .fwd_a        (fwd_a_raw),
    .fwd_b        (fwd_b_raw)
  );

  assign fwd_a    = reset ? FWD_RF : fwd_a_raw;
  assign fwd_b    = reset ? FWD_RF : fwd_b_raw;
  assign dmem_err = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      err_q    <= err_q | (state_next == ERR);
    end
  end

  // Freeze beats branch flush, which beats the load-use bubble; reset overrides all.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    dmem_req      = 1'b0;
    frozen        = 1'b0;
    pc_we         = 1'b1;
    if_id_we      = 1'b1;
    id_ex_we      = 1'b1;
    ex_mem_we     = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    mem_wb_flush  = 1'b0;

    mem_access = mem_memread | mem_memwrite;
    load_use   = ex_memread && (ex_rd != 5'd0) && ((ex_rd == id_rs) || (ex_rd == id_rt));

    unique case (state)
      RUN: begin
        dmem_req = mem_access;
        frozen   = mem_access && !dmem_ack;
        if (frozen) begin
          state_next    = MEM_WAIT;
          wait_cnt_next = '0;
        end
      end
      MEM_WAIT: begin
        dmem_req = 1'b1;
        frozen   = !dmem_ack;
        if (dmem_ack)
          state_next = RUN;
        else if (wait_cnt == WAIT_LAST)
          state_next = ERR;
        else
          wait_cnt_next = wait_cnt + CW'(1);
      end
      ERR: begin
        frozen = 1'b1;
      end
      default: begin
        state_next = RUN;
      end
    endcase

    if (reset) begin
      dmem_req     = 1'b0;
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      id_ex_we     = 1'b0;
      ex_mem_we    = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (frozen) begin
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      id_ex_we     = 1'b0;
      ex_mem_we    = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (ex_branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      pc_we       = 1'b0;
      if_id_we    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic        flush_evt;
  logic [31:0] stall_q, flush_q;

  assign flush_evt = !reset && !frozen && ex_branch_taken;

  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_we && (stall_q != 32'hFFFF_FFFF))
        stall_q <= stall_q + 32'd1;
      if (flush_evt && (flush_q != 32'hFFFF_FFFF))
        flush_q <= flush_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_events = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the hazard rules.
module tb_pipeline_hazard_ctrl;

  localparam int WAIT_MAX = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic        ex_memread, ex_branch_taken, mem_regwrite, mem_memread, mem_memwrite;
  logic        wb_regwrite, dmem_ack;
  logic        dmem_req, pc_we, if_id_we, id_ex_we, ex_mem_we;
  logic        if_id_flush, id_ex_flush, mem_wb_flush, dmem_err;
  logic [1:0]  fwd_a, fwd_b;
  logic [31:0] stall_cycles, flush_events;

  int total = 0;
  int bad   = 0;

  // Model state: access pending, terminal error, number of wait cycles spent so far.
  bit          m_pending = 0;
  bit          m_errored = 0;
  int          m_waited  = 0;
  longint      m_stall   = 0;
  longint      m_flush   = 0;
  logic [11:0] exp_vec;
  bit          exp_pc_we, exp_branch_flush;
  int          freeze_seen;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_memread(ex_memread), .ex_branch_taken(ex_branch_taken),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .dmem_ack(dmem_ack),
    .dmem_req(dmem_req), .pc_we(pc_we), .if_id_we(if_id_we), .id_ex_we(id_ex_we),
    .ex_mem_we(ex_mem_we), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .mem_wb_flush(mem_wb_flush), .fwd_a(fwd_a), .fwd_b(fwd_b), .dmem_err(dmem_err),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  function automatic logic [1:0] fwdPick(input logic [4:0] src);
    if (mem_regwrite && mem_rd != 0 && mem_rd == src) return 2'b10;
    if (wb_regwrite && wb_rd != 0 && wb_rd == src) return 2'b01;
    return 2'b00;
  endfunction

  // Vector order: req, pc_we, if_id_we, id_ex_we, ex_mem_we, if_id_fl, id_ex_fl, mem_wb_fl, fwd_a, fwd_b
  task automatic predict();
    bit access, req, stop, hazard;
    access = mem_memread || mem_memwrite;
    exp_branch_flush = 0;
    if (reset) begin
      exp_vec   = {1'b0, 4'b0000, 3'b111, 2'b00, 2'b00};
      exp_pc_we = 0;
      return;
    end
    req    = !m_errored && (m_pending || access);
    stop   = m_errored || (req && !dmem_ack);
    hazard = ex_memread && ex_rd != 0 && (ex_rd == id_rs || ex_rd == id_rt);
    if (stop)
      exp_vec = {req, 4'b0000, 3'b001, 4'b0};
    else if (ex_branch_taken) begin
      exp_vec = {req, 4'b1111, 3'b110, 4'b0};
      exp_branch_flush = 1;
    end else if (hazard)
      exp_vec = {req, 4'b0011, 3'b010, 4'b0};
    else
      exp_vec = {req, 4'b1111, 3'b000, 4'b0};
    exp_vec[3:0] = {fwdPick(ex_rs), fwdPick(ex_rt)};
    exp_pc_we = exp_vec[10];
  endtask

  task automatic clearInputs();
    reset = 0; id_rs = 0; id_rt = 0; ex_rs = 0; ex_rt = 0; ex_rd = 0; mem_rd = 0; wb_rd = 0;
    ex_memread = 0; ex_branch_taken = 0; mem_regwrite = 0; mem_memread = 0;
    mem_memwrite = 0; wb_regwrite = 0; dmem_ack = 0;
  endtask

  // Settle combinational outputs, then compare everything against the model.
  task automatic applyStimulus();
    #1;
    predict();
    checkOutput("decision", {dmem_req, pc_we, if_id_we, id_ex_we, ex_mem_we,
                             if_id_flush, id_ex_flush, mem_wb_flush, fwd_a, fwd_b}, exp_vec);
    checkOutput("dmem_err", dmem_err, m_errored);
`ifdef HAZ_PERF_CNT_EN
    checkOutput("stall_cycles", stall_cycles, m_stall);
    checkOutput("flush_events", flush_events, m_flush);
`else
    checkOutput("stall_cycles", stall_cycles, 0);
    checkOutput("flush_events", flush_events, 0);
`endif
  endtask

  task automatic clockEdge();
    bit access;
    @(posedge clk);
    access = mem_memread || mem_memwrite;
    if (reset) begin
      m_pending = 0; m_errored = 0; m_waited = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (!exp_pc_we && m_stall < 64'hFFFF_FFFF) m_stall++;
      if (exp_branch_flush && m_flush < 64'hFFFF_FFFF) m_flush++;
      if (!m_errored) begin
        if (m_pending) begin
          if (dmem_ack) m_pending = 0;
          else begin
            m_waited++;
            if (m_waited == WAIT_MAX) begin m_pending = 0; m_errored = 1; end
          end
        end else if (access && !dmem_ack) begin
          m_pending = 1; m_waited = 0;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic loadUse();
    clearInputs(); ex_memread = 1; ex_rd = 8; id_rs = 8;
    applyStimulus(); clockEdge();
    clearInputs(); applyStimulus(); clockEdge();
  endtask

  task automatic branchTaken();
    clearInputs(); ex_branch_taken = 1;
    applyStimulus(); clockEdge();
  endtask

  initial begin
    clearInputs();
    reset = 1; mem_memread = 1; dmem_ack = 1; ex_rs = 5; mem_rd = 5; mem_regwrite = 1;
    @(negedge clk);
    applyStimulus();
    checkOutput("rst_pc_we", pc_we, 0);
    checkOutput("rst_flush", {if_id_flush, id_ex_flush, mem_wb_flush}, 3'b111);
    checkOutput("rst_req", dmem_req, 0);
    checkOutput("rst_fwd_a", fwd_a, 2'b00);
    clockEdge();

    // Load-use: one bubble, then everything advances.
    clearInputs(); ex_memread = 1; ex_rd = 8; id_rs = 8;
    applyStimulus();
    checkOutput("lu_stall", {pc_we, if_id_we, id_ex_flush, id_ex_we, ex_mem_we}, 5'b00111);
    checkOutput("dmem_err_after_reset", dmem_err, 0);
    clockEdge();
    clearInputs(); applyStimulus();
    checkOutput("lu_release", {pc_we, if_id_we, id_ex_we, ex_mem_we}, 4'b1111);
    clockEdge();

    // Branch beats load-use.
    clearInputs(); ex_branch_taken = 1; ex_memread = 1; ex_rd = 8; id_rt = 8;
    applyStimulus();
    checkOutput("br_flush", {if_id_flush, id_ex_flush, pc_we}, 3'b111);
    clockEdge();

    // Three wait states then ack.
    freeze_seen = 0;
    for (int i = 0; i < 4; i++) begin
      clearInputs(); mem_memread = 1; dmem_ack = (i == 3);
      applyStimulus();
      checkOutput("mw_req", dmem_req, 1);
      if (!pc_we && mem_wb_flush) freeze_seen++;
      clockEdge();
    end
    checkOutput("mw_freeze_count", freeze_seen, 3);

    // Zero-wait access.
    clearInputs(); mem_memwrite = 1; dmem_ack = 1;
    applyStimulus();
    checkOutput("zw_nostall", {dmem_req, pc_we, mem_wb_flush}, 3'b110);
    clockEdge();

    // Forwarding priorities.
    clearInputs(); ex_rs = 5; mem_rd = 5; wb_rd = 5; mem_regwrite = 1; wb_regwrite = 1;
    applyStimulus(); checkOutput("fwd_mem", fwd_a, 2'b10);
    ex_rs = 0; applyStimulus(); checkOutput("fwd_zero", fwd_a, 2'b00);
    ex_rs = 5; mem_regwrite = 0; applyStimulus(); checkOutput("fwd_wb", fwd_a, 2'b01);
    clockEdge();

    // Performance counters from a clean reset.
    clearInputs(); reset = 1; applyStimulus(); clockEdge();
    for (int i = 0; i < 3; i++) loadUse();
    for (int i = 0; i < 2; i++) branchTaken();
    clearInputs(); applyStimulus();
`ifdef HAZ_PERF_CNT_EN
    checkOutput("perf_stall", stall_cycles, 3);
    checkOutput("perf_flush", flush_events, 2);
`else
    checkOutput("perf_stall", stall_cycles, 0);
    checkOutput("perf_flush", flush_events, 0);
`endif
    clockEdge();

    // Timeout: no ack ever; one RUN freeze cycle plus WAIT_MAX wait cycles.
    for (int i = 0; i < WAIT_MAX + 1; i++) begin
      clearInputs(); mem_memread = 1;
      applyStimulus(); clockEdge();
    end
    clearInputs(); mem_memread = 1; dmem_ack = 1;
    applyStimulus();
    checkOutput("to_err", {dmem_err, dmem_req, pc_we, mem_wb_flush}, 4'b1001);
    clockEdge();
    clearInputs(); reset = 1; applyStimulus(); clockEdge();
    clearInputs(); applyStimulus();
    checkOutput("to_recover", {dmem_err, pc_we}, 2'b01);
    clockEdge();

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      reset           = ($urandom_range(0, 59) == 0);
      id_rs           = 5'($urandom_range(0, 3));
      id_rt           = 5'($urandom_range(0, 3));
      ex_rs           = 5'($urandom_range(0, 3));
      ex_rt           = 5'($urandom_range(0, 3));
      ex_rd           = 5'($urandom_range(0, 3));
      mem_rd          = 5'($urandom_range(0, 3));
      wb_rd           = 5'($urandom_range(0, 3));
      ex_memread      = ($urandom_range(0, 2) == 0);
      ex_branch_taken = ($urandom_range(0, 5) == 0);
      mem_regwrite    = $urandom_range(0, 1);
      wb_regwrite     = $urandom_range(0, 1);
      mem_memread     = ($urandom_range(0, 3) == 0);
      mem_memwrite    = ($urandom_range(0, 3) == 0);
      dmem_ack        = $urandom_range(0, 1);
      applyStimulus();
      clockEdge();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
